// File: rtl/ppm_decoder.sv
// PPM receive decoder: recovers the pulse slot of each frame from the encoder's
// pulse stream and flags frames that carry no pulse or several pulses.
module ppm_decoder #(
  parameter int POS_W       = 8,
  parameter int FRAME_LEN   = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             frame_start,
  input  logic             ppm_in,
  output logic [POS_W-1:0] pos_out,
  output logic             pos_valid,
  output logic             err_none,
  output logic             err_multi,
  output logic             locked
);

  typedef enum logic [1:0] {
    IDLE,
    ACQ,
    GOT,
    MULTI
  } state_t;

  localparam logic [POS_W-1:0] LastSlot = POS_W'(FRAME_LEN - 1);

  logic ppmAligned;
  logic fsAligned;

  generate
    if (SYNC_STAGES == 0) begin : gNoSync
      assign ppmAligned = ppm_in;
      assign fsAligned  = frame_start;
    end else begin : gSync
      logic [SYNC_STAGES-1:0] ppmSync_q;
      logic [SYNC_STAGES-1:0] fsSync_q;

      // frame_start rides through the same flops so slot arithmetic stays aligned
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ppmSync_q <= '0;
          fsSync_q  <= '0;
        end else begin
          ppmSync_q[0] <= ppm_in;
          fsSync_q[0]  <= frame_start;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            ppmSync_q[i] <= ppmSync_q[i-1];
            fsSync_q[i]  <= fsSync_q[i-1];
          end
        end
      end

      assign ppmAligned = ppmSync_q[SYNC_STAGES-1];
      assign fsAligned  = fsSync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic             ppmPrev_q;
  logic             edgeSeen_q;
  logic             boundary_q;
  logic             fsSeen_q;
  logic [POS_W-1:0] slotCnt_q;
  logic [POS_W-1:0] slotCnt_d;
  logic             atLast;

  assign atLast = (slotCnt_q == LastSlot);

  always_comb begin
    slotCnt_d = slotCnt_q + 1'b1;
    if (fsAligned || atLast) begin
      slotCnt_d = '0;
    end
  end

  // A frame_start landing on the wrap raises boundary_q once, so it counts once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ppmPrev_q  <= 1'b0;
      edgeSeen_q <= 1'b0;
      boundary_q <= 1'b0;
      fsSeen_q   <= 1'b0;
      slotCnt_q  <= '0;
    end else if (ena) begin
      ppmPrev_q  <= ppmAligned;
      edgeSeen_q <= ppmAligned & ~ppmPrev_q;
      boundary_q <= fsAligned | atLast;
      fsSeen_q   <= fsAligned;
      slotCnt_q  <= slotCnt_d;
    end
  end

  state_t           state_q;
  logic [POS_W-1:0] capture_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      capture_q <= '0;
      pos_out   <= '0;
      pos_valid <= 1'b0;
      err_none  <= 1'b0;
      err_multi <= 1'b0;
      locked    <= 1'b0;
    end else begin
      pos_valid <= 1'b0;
      err_none  <= 1'b0;
      err_multi <= 1'b0;
      if (ena) begin
        case (state_q)
          IDLE: begin
            if (fsSeen_q) begin
              state_q <= ACQ;
              locked  <= 1'b1;
            end
          end
          ACQ, GOT, MULTI: begin
            if (boundary_q) begin
              pos_valid <= (state_q == GOT);
              err_none  <= (state_q == ACQ);
              err_multi <= (state_q == MULTI);
              if (state_q == GOT) begin
                pos_out <= capture_q;
              end
              // An edge on the boundary cycle opens the new frame at slot 0
              if (edgeSeen_q) begin
                state_q   <= GOT;
                capture_q <= slotCnt_q;
              end else begin
                state_q <= ACQ;
              end
            end else if (edgeSeen_q) begin
              if (state_q == ACQ) begin
                state_q   <= GOT;
                capture_q <= slotCnt_q;
              end else begin
                state_q <= MULTI;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ppm_decoder.sv
// Directed testbench for ppm_decoder with default parameters: each frame's
// result is observed while the following frame is being driven.
module tb_ppm_decoder;

  localparam int PosW       = 8;
  localparam int FrameLen   = 256;
  localparam int SyncStages = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            ena;
  logic            frame_start;
  logic            ppm_in;
  logic [PosW-1:0] pos_out;
  logic            pos_valid;
  logic            err_none;
  logic            err_multi;
  logic            locked;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nValid, nNone, nMulti;
  int validCyc, noneCyc, multiCyc;
  int badPos = 0;
  int fsEdgePrev = 0;
  int fsEdgeCur  = 0;
  logic [PosW-1:0] lastPos;

  ppm_decoder #(
    .POS_W(PosW),
    .FRAME_LEN(FrameLen),
    .SYNC_STAGES(SyncStages)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .frame_start(frame_start),
    .ppm_in(ppm_in),
    .pos_out(pos_out),
    .pos_valid(pos_valid),
    .err_none(err_none),
    .err_multi(err_multi),
    .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    nValid   = 0;
    nNone    = 0;
    nMulti   = 0;
    validCyc = -1;
    noneCyc  = -1;
    multiCyc = -1;
  endtask

  // Outputs are sampled 1 ns after each rising edge; cyc counts rising edges
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (pos_valid === 1'b1) begin nValid++; validCyc = cyc; end
    if (err_none === 1'b1) begin nNone++; noneCyc = cyc; end
    if (err_multi === 1'b1) begin nMulti++; multiCyc = cyc; end
    if (pos_out !== lastPos && pos_valid !== 1'b1) badPos++;
    lastPos = pos_out;
  endtask

  // Drives one frame: ppm high over [aLo,aHi] and [bLo,bHi], ena low over [enaLo,enaHi]
  task automatic applyStimulus(input int len, input bit sendFs, input int aLo, input int aHi,
                               input int bLo, input int bHi, input int enaLo, input int enaHi);
    clearCounts();
    for (int s = 0; s < len; s++) begin
      frame_start = sendFs && (s == 0);
      ppm_in      = (s >= aLo && s <= aHi) || (s >= bLo && s <= bHi);
      ena         = !(s >= enaLo && s <= enaHi);
      if (sendFs && s == 0) begin
        fsEdgePrev = fsEdgeCur;
        fsEdgeCur  = cyc + 1;
      end
      tick();
    end
    frame_start = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    ena         = 1'b1;
    frame_start = 1'b0;
    ppm_in      = 1'b0;
    lastPos     = '0;
    #12;
    checkOutput("reset pos_out", 32'(pos_out), 0);
    checkOutput("reset pos_valid", 32'(pos_valid), 0);
    checkOutput("reset err_none", 32'(err_none), 0);
    checkOutput("reset err_multi", 32'(err_multi), 0);
    checkOutput("reset locked", 32'(locked), 0);
    #10;
    rst = 1'b0;
    $display("[TB] reset released");

    // Strobe for a frame lands FrameLen + SyncStages + 1 = 259 edges after its frame_start edge
    applyStimulus(256, 1'b1, 100, 103, -1, -1, -1, -1);
    applyStimulus(256, 1'b1, -1, -1, -1, -1, -1, -1);
    checkOutput("f1 valid count", nValid, 1);
    checkOutput("f1 valid cycle", validCyc, fsEdgePrev + 259);
    checkOutput("f1 pos_out", 32'(pos_out), 100);
    checkOutput("f1 none count", nNone, 0);
    checkOutput("f1 multi count", nMulti, 0);
    checkOutput("f1 locked", 32'(locked), 1);

    applyStimulus(256, 1'b1, 10, 10, 200, 200, -1, -1);
    checkOutput("f2 none count", nNone, 1);
    checkOutput("f2 none cycle", noneCyc, fsEdgePrev + 259);
    checkOutput("f2 valid count", nValid, 0);
    checkOutput("f2 pos_out held", 32'(pos_out), 100);

    applyStimulus(256, 1'b1, 37, 37, -1, -1, -1, -1);
    checkOutput("f3 multi count", nMulti, 1);
    checkOutput("f3 multi cycle", multiCyc, fsEdgePrev + 259);
    checkOutput("f3 valid count", nValid, 0);
    checkOutput("f3 pos_out held", 32'(pos_out), 100);

    applyStimulus(256, 1'b1, 0, 0, -1, -1, -1, -1);
    checkOutput("f4 valid count", nValid, 1);
    checkOutput("f4 pos_out", 32'(pos_out), 37);

    applyStimulus(256, 1'b1, 255, 255, -1, -1, -1, -1);
    checkOutput("f5 slot0 valid count", nValid, 1);
    checkOutput("f5 slot0 pos_out", 32'(pos_out), 0);

    applyStimulus(256, 1'b1, 254, 255, -1, -1, -1, -1);
    checkOutput("f6 slot255 valid count", nValid, 1);
    checkOutput("f6 slot255 pos_out", 32'(pos_out), 255);

    // Pulse continues from slot 254 into slots 0..2 of the next frame
    applyStimulus(256, 1'b1, 0, 2, -1, -1, -1, -1);
    checkOutput("f7 span valid count", nValid, 1);
    checkOutput("f7 span pos_out", 32'(pos_out), 254);

    applyStimulus(150, 1'b1, 100, 101, -1, -1, -1, -1);
    checkOutput("f8 span none count", nNone, 1);
    checkOutput("f8 span none cycle", noneCyc, fsEdgePrev + 259);
    checkOutput("f8 span valid count", nValid, 0);

    // Early frame_start at slot 150: result follows the aligned strobe by one cycle
    applyStimulus(256, 1'b1, 5, 5, -1, -1, -1, -1);
    checkOutput("f9 early valid count", nValid, 1);
    checkOutput("f9 early valid cycle", validCyc, fsEdgeCur + SyncStages + 1);
    checkOutput("f9 early pos_out", 32'(pos_out), 100);

    applyStimulus(256, 1'b1, 60, 62, -1, -1, 50, 80);
    checkOutput("f10 restart pos_out", 32'(pos_out), 5);
    checkOutput("f10 restart valid cycle", validCyc, fsEdgePrev + 259);

    // Frame stretched by ena-low cycles, so the next frame_start ends it early
    applyStimulus(256, 1'b1, 200, 200, -1, -1, -1, -1);
    checkOutput("f11 ena none count", nNone, 1);
    checkOutput("f11 ena none cycle", noneCyc, fsEdgeCur + SyncStages + 1);
    checkOutput("f11 ena valid count", nValid, 0);
    checkOutput("f11 ena multi count", nMulti, 0);

    applyStimulus(120, 1'b1, 100, 101, -1, -1, -1, -1);
    checkOutput("f12 resume valid count", nValid, 1);
    checkOutput("f12 resume pos_out", 32'(pos_out), 200);

    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst pos_out", 32'(pos_out), 0);
    checkOutput("midrst pos_valid", 32'(pos_valid), 0);
    checkOutput("midrst err_none", 32'(err_none), 0);
    checkOutput("midrst err_multi", 32'(err_multi), 0);
    checkOutput("midrst locked", 32'(locked), 0);
    lastPos = '0;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;

    applyStimulus(300, 1'b0, 30, 31, 280, 281, -1, -1);
    checkOutput("unlocked valid count", nValid, 0);
    checkOutput("unlocked none count", nNone, 0);
    checkOutput("unlocked multi count", nMulti, 0);
    checkOutput("unlocked locked", 32'(locked), 0);

    applyStimulus(256, 1'b1, 77, 77, -1, -1, -1, -1);
    applyStimulus(256, 1'b1, -1, -1, -1, -1, -1, -1);
    checkOutput("relock valid count", nValid, 1);
    checkOutput("relock valid cycle", validCyc, fsEdgePrev + 259);
    checkOutput("relock pos_out", 32'(pos_out), 77);
    checkOutput("relock locked", 32'(locked), 1);

    checkOutput("pos_out changed without valid", badPos, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppm_decoder.md
Name: ppm_decoder

Overview:
- Receiver stage directly downstream of tt_um_ppm_encoder. Consumes the single-wire PPM pulse stream and the shared frame-start strobe.
- Recovers the slot index of the pulse in each frame and reports it with a one-cycle valid strobe.
- Flags frames that contain no pulse or more than one pulse.
- Sits in the loopback/receive path of the TT tile, clocked at 100 MHz with the encoder.

Parameters:
- POS_W, 8: width of the slot index and pos_out.
- FRAME_LEN, 256: slots per frame. Must satisfy 2 <= FRAME_LEN <= 2^POS_W.
- SYNC_STAGES, 2: synchroniser flops on ppm_in. 0 bypasses the synchroniser.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  tile enable. When low, decode state holds.
- frame_start  in  1  synchronous one-cycle strobe marking slot 0 of a frame.
- ppm_in  in  1  PPM pulse stream, may be multi-cycle wide.
- pos_out  out  POS_W  last successfully decoded slot index.
- pos_valid  out  1  one-cycle strobe: pos_out updated this cycle.
- err_none  out  1  one-cycle strobe: frame ended with no pulse.
- err_multi  out  1  one-cycle strobe: frame ended with two or more pulses.
- locked  out  1  high once the first frame_start has been accepted.

Behaviour:
- Reset (async): all outputs 0, state IDLE, slot counter 0, synchroniser and edge registers 0.
  - Reset mid-frame discards that frame; no strobe is emitted.
- Alignment:
  - ppm_in passes through SYNC_STAGES flops.
  - frame_start is delayed by the same SYNC_STAGES flops, so both signals are aligned.
  - All slot arithmetic uses the aligned signals.
- Edge detect: a pulse is a 0->1 transition of aligned ppm_in versus the previous aligned sample. Pulse width is irrelevant.
- Slot counter:
  - Loads 0 on aligned frame_start.
  - Otherwise increments, wrapping FRAME_LEN-1 -> 0.
  - Frame boundary = aligned frame_start OR the wrap.
- States: IDLE, ACQ (0 edges seen), GOT (1 edge, index captured), MULTI (2 or more edges).
  - IDLE -> ACQ on aligned frame_start. locked is set at this point and cleared only by rst.
  - Edges in IDLE are ignored.
  - ACQ -> GOT on an edge; the current slot count is captured.
  - GOT -> MULTI on any further edge.
  - MULTI holds until the boundary.
- At a frame boundary in ACQ/GOT/MULTI:
  - Outputs are registered and appear the cycle after the boundary.
  - Exactly one of the following strobes fires for one cycle:
    - GOT: pos_valid=1, pos_out=captured index.
    - ACQ: err_none=1.
    - MULTI: err_multi=1.
  - pos_out changes only with pos_valid.
  - State returns to ACQ.
- Edge on the boundary cycle belongs to the new frame and is recorded at slot 0 after the evaluation.
- Pulse held high across a boundary generates no edge in the new frame.
- Early frame_start (before wrap) terminates the current frame normally and restarts slot 0.
- frame_start coinciding with the wrap counts as one boundary only.
- ena low:
  - Slot counter, state and edge history hold; no strobes are issued.
  - Synchroniser flops keep shifting.
  - An edge that occurs while ena is low is not counted.
- Latency (ena high, no early frame_start): the evaluation strobe for a frame begins exactly FRAME_LEN + SYNC_STAGES + 1 rising edges after the edge that samples frame_start.

Test Plan:
- rst 20 ns then release; frame_start at cycle 0; ppm_in high slots 100..103 -> pos_valid one cycle at cycle 259 (defaults), pos_out=100, locked=1, no error strobes.
- Next frame with no pulse -> err_none one cycle at cycle 515; pos_out stays 100; pos_valid stays 0.
- Pulses at slots 10 and 200 -> err_multi one cycle; pos_out stays 100. Following frame with a pulse at 37 -> pos_out=37.
- Boundary cases, each -> the listed result:
  - Pulse at slot 255 -> 255.
  - Pulse at slot 0 -> 0.
  - Pulse spanning slots 254..2 of the next frame -> 254 for the first frame, then err_none for the next frame.
- Early frame_start at slot 150 after a pulse at 100 -> pos_valid with 100 one cycle after the aligned strobe; next frame counts from 0.
- ena low over slots 50..80 with a pulse at 60 -> frame reports err_none and slot count resumes.
- rst asserted at slot 120 -> all outputs 0 immediately; locked=0; no strobes until a new frame_start.
